// File: rtl/sc_mm_controller.sv
// ---------------------------------------------------------------------------
// sc_mm_controller
// Sequencer for the stochastic matrix-multiply datapath
// (operand regs -> SNGs -> sc_matrix_mult -> sd_converters).
// A start request latches the operands and clears the converters. The SNGs
// then run through the pipeline fill, and the converter count window is
// opened for exactly 2^COUNT_WIDTH cycles. The result is then held valid
// until the consumer accepts it.
//
// Parameters
//   COUNT_WIDTH  : count window is 2^COUNT_WIDTH cycles (converter precision)
//   PIPE_LATENCY : cycles from sng_en rising to first valid stochastic bit (0 ok)
//   JOB_WIDTH    : width of the completed-job counter
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-low reset
//   start      in   job request (honoured in IDLE or on the HOLD handshake)
//   abort      in   synchronous abort, returns to IDLE
//   opnd_load  out  1-cycle pulse: latch input/weight matrices
//   sd_clr     out  1-cycle pulse with opnd_load: clear converter accumulators
//   sng_en     out  SNGs / matrix-mult advance while high
//   sd_en      out  sd_converters accumulate while high
//   sd_last    out  final cycle of the count window
//   out_valid  out  output matrix valid, held until out_ready
//   out_ready  in   consumer accepts when out_valid & out_ready
//   busy       out  high in every state except IDLE
//   job_count  out  number of accepted results, wraps
// ---------------------------------------------------------------------------
module sc_mm_controller #(
    parameter int COUNT_WIDTH  = 8,
    parameter int PIPE_LATENCY = 2,
    parameter int JOB_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 opnd_load,
    output logic                 sd_clr,
    output logic                 sng_en,
    output logic                 sd_en,
    output logic                 sd_last,
    output logic                 out_valid,
    output logic                 busy,
    output logic [JOB_WIDTH-1:0] job_count
);

    // The fill counter needs at least one bit even when FILL is never used.
    localparam int FILL_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST =
        (PIPE_LATENCY > 0) ? FILL_W'(PIPE_LATENCY - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        COUNT,
        HOLD
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [FILL_W-1:0]      fill_cnt;
    logic [FILL_W-1:0]      fill_nx;
    logic [COUNT_WIDTH-1:0] win_cnt;
    logic [COUNT_WIDTH-1:0] win_nx;
    logic                   job_inc;

    // Next-state and counter update. Abort wins over everything, including
    // a HOLD handshake, so an aborted job is never counted. The window
    // counter wraps to zero by itself on its last cycle, so it is already
    // clean for the next job.
    always_comb begin
        state_nx = state;
        fill_nx  = fill_cnt;
        win_nx   = win_cnt;
        job_inc  = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            fill_nx  = '0;
            win_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx = LOAD;
                    end
                end
                LOAD: begin
                    fill_nx  = '0;
                    win_nx   = '0;
                    state_nx = (PIPE_LATENCY == 0) ? COUNT : FILL;
                end
                FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        fill_nx  = '0;
                        state_nx = COUNT;
                    end else begin
                        fill_nx = fill_cnt + 1'b1;
                    end
                end
                COUNT: begin
                    win_nx = win_cnt + 1'b1;
                    if (&win_cnt) begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        job_inc  = 1'b1;
                        state_nx = start ? LOAD : IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    fill_nx  = '0;
                    win_nx   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs. Each output is decoded from
    // the state/counter values that are being loaded, so every strobe lines
    // up exactly with the state it belongs to, without a combinational path
    // from inputs to outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            job_count <= '0;
            opnd_load <= 1'b0;
            sd_clr    <= 1'b0;
            sng_en    <= 1'b0;
            sd_en     <= 1'b0;
            sd_last   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            fill_cnt  <= fill_nx;
            win_cnt   <= win_nx;
            if (job_inc) begin
                job_count <= job_count + 1'b1;
            end
            opnd_load <= (state_nx == LOAD);
            sd_clr    <= (state_nx == LOAD);
            sng_en    <= (state_nx == FILL) || (state_nx == COUNT);
            sd_en     <= (state_nx == COUNT);
            sd_last   <= (state_nx == COUNT) && (&win_nx);
            out_valid <= (state_nx == HOLD);
            busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sc_mm_controller.sv
// ---------------------------------------------------------------------------
// tb_sc_mm_controller
// Drives two controller instances with the same inputs:
//   A : COUNT_WIDTH=3, PIPE_LATENCY=2, JOB_WIDTH=3 (small so the count wraps)
//   B : COUNT_WIDTH=2, PIPE_LATENCY=0, JOB_WIDTH=4 (no pipeline fill)
// A reference model tracks each job as "cycles since the load cycle". From
// that offset it derives every strobe with simple arithmetic on L and 2^W.
// ---------------------------------------------------------------------------
module tb_sc_mm_controller;

    localparam int WA = 3, LA = 2, JA = 3;
    localparam int WB = 2, LB = 0, JB = 4;

    logic clk;
    logic rst;
    logic start, abort, out_ready;

    logic          opnd_load_a, sd_clr_a, sng_en_a, sd_en_a, sd_last_a, out_valid_a, busy_a;
    logic [JA-1:0] job_count_a;
    logic          opnd_load_b, sd_clr_b, sng_en_b, sd_en_b, sd_last_b, out_valid_b, busy_b;
    logic [JB-1:0] job_count_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-instance job model: active job, cycles since load, accepted jobs.
    typedef struct {
        bit active;
        int t;
        int jobs;
    } model_t;

    model_t m[2];

    sc_mm_controller #(.COUNT_WIDTH(WA), .PIPE_LATENCY(LA), .JOB_WIDTH(JA)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .opnd_load(opnd_load_a), .sd_clr(sd_clr_a), .sng_en(sng_en_a), .sd_en(sd_en_a),
        .sd_last(sd_last_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .busy(busy_a), .job_count(job_count_a)
    );

    sc_mm_controller #(.COUNT_WIDTH(WB), .PIPE_LATENCY(LB), .JOB_WIDTH(JB)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .opnd_load(opnd_load_b), .sd_clr(sd_clr_b), .sng_en(sng_en_b), .sd_en(sd_en_b),
        .sd_last(sd_last_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .busy(busy_b), .job_count(job_count_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected strobes {opnd_load, sd_clr, sng_en, sd_en, sd_last, out_valid, busy}.
    // t=0 is the load cycle, t=1..L is the fill, t=L+1..L+2^W is the count
    // window, and anything later is the hold phase.
    function automatic logic [6:0] expStrobes(input model_t mm, input int lat, input int w);
        int n;
        int last;
        logic [6:0] e;
        n    = 1 << w;
        last = lat + n;
        e    = '0;
        if (mm.active) begin
            e[6] = (mm.t == 0);
            e[5] = (mm.t == 0);
            e[4] = (mm.t >= 1) && (mm.t <= last);
            e[3] = (mm.t >= lat + 1) && (mm.t <= last);
            e[2] = (mm.t == last);
            e[1] = (mm.t > last);
            e[0] = 1'b1;
        end
        return e;
    endfunction

    // Advance one job model by one clock edge with the sampled inputs.
    function automatic model_t stepModel(input model_t mm, input int lat, input int w, input int jw,
                                         input bit s, input bit a, input bit r);
        model_t nx;
        nx = mm;
        if (a) begin
            nx.active = 1'b0;
            nx.t      = 0;
        end else if (!mm.active) begin
            if (s) begin
                nx.active = 1'b1;
                nx.t      = 0;
            end
        end else if (mm.t <= lat + (1 << w)) begin
            nx.t = mm.t + 1;
        end else if (r) begin
            nx.jobs   = (mm.jobs + 1) % (1 << jw);
            nx.active = s;
            nx.t      = 0;
        end
        return nx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("strobes_a",
                    {25'b0, opnd_load_a, sd_clr_a, sng_en_a, sd_en_a, sd_last_a, out_valid_a, busy_a},
                    {25'b0, expStrobes(m[0], LA, WA)});
        checkOutput("jobs_a", {29'b0, job_count_a}, 32'(m[0].jobs));
        checkOutput("strobes_b",
                    {25'b0, opnd_load_b, sd_clr_b, sng_en_b, sd_en_b, sd_last_b, out_valid_b, busy_b},
                    {25'b0, expStrobes(m[1], LB, WB)});
        checkOutput("jobs_b", {28'b0, job_count_b}, 32'(m[1].jobs));
    endtask

    // Drive inputs just after an edge, advance one cycle, update models, check.
    task automatic applyStimulus(input bit s, input bit a, input bit r);
        start     = s;
        abort     = a;
        out_ready = r;
        @(posedge clk);
        m[0] = stepModel(m[0], LA, WA, JA, s, a, r);
        m[1] = stepModel(m[1], LB, WB, JB, s, a, r);
        cyc++;
        #1;
        compareAll();
    endtask

    task automatic resetModels();
        for (int i = 0; i < 2; i++) begin
            m[i].active = 1'b0;
            m[i].t      = 0;
            m[i].jobs   = 0;
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic asyncReset();
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #2;
        resetModels();
        compareAll();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        compareAll();
    endtask

    initial begin
        int guard;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        resetModels();
        #3;
        compareAll();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compareAll();

        // Single job with a late consumer: out_valid must hold for 5 extra cycles.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Back-to-back jobs: start held high with ready, busy never drops.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Abort in the count window of A at win_cnt=4, then a fresh job.
        applyStimulus(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(m[0].active && m[0].t == LA + 1 + 4) && guard < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("abort_reach", 32'(guard < 20), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Bring A's job count to its maximum, then reset during the fill.
        guard = 0;
        while (m[0].jobs != (1 << JA) - 1 && guard < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            guard++;
        end
        checkOutput("jobs_max_reach", 32'(m[0].jobs), 32'((1 << JA) - 1));
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        asyncReset();

        // 2^JOB_WIDTH jobs after reset bring A's counter back around to 0.
        guard = 0;
        for (int j = 0; j < (1 << JA); j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            while (m[0].active && guard < 400) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                guard++;
            end
        end
        checkOutput("wrap_a", {29'b0, job_count_a}, 32'd0);

        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
